// File: rtl/nms_scheduler.sv
// Whole-frame sequencer for FAST9 non-maximum suppression: scans interior pixels,
// loads centre and neighbour scores into the NMS datapath and reports local maxima.
module nms_scheduler #(
   parameter int IMG_W  = 30,
   parameter int IMG_H  = 30,
   parameter int ADDR_W = 15,
   parameter int BORDER = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic              center_nz,
   output logic [3:0]        adj_number,
   output logic              reg_wr,
   output logic              eval,
   input  logic              is_max,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       corner_count,
   output logic [2:0]        fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CENTER = 3'd1,
      S_ADJ    = 3'd2,
      S_EVAL   = 3'd3,
      S_RESULT = 3'd4,
      S_NEXT   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam int X_LAST = IMG_W - 1 - BORDER;
   localparam int Y_LAST = IMG_H - 1 - BORDER;
   localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(BORDER * IMG_W + BORDER);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * BORDER + 1);

   state_t            state;
   logic [ADDR_W-1:0] cx;
   logic [ADDR_W-1:0] cy;
   logic [ADDR_W-1:0] c;

   function automatic logic [ADDR_W-1:0] nb(input logic [ADDR_W-1:0] ca, input logic [3:0] k);
      logic [ADDR_W-1:0] a;
      case (k)
         4'd0:    a = ca - W_A - ONE_A;
         4'd1:    a = ca - W_A;
         4'd2:    a = ca - W_A + ONE_A;
         4'd3:    a = ca - ONE_A;
         4'd4:    a = ca + ONE_A;
         4'd5:    a = ca + W_A - ONE_A;
         4'd6:    a = ca + W_A;
         4'd7:    a = ca + W_A + ONE_A;
         default: a = ca;
      endcase
      return a;
   endfunction

   // rd_req is high exactly in CENTER/ADJ, so this is the ack-qualified load strobe.
   assign reg_wr    = rd_req & rd_ack;
   assign fsm_state = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_req       <= 1'b0;
         rd_addr      <= '0;
         adj_number   <= '0;
         eval         <= 1'b0;
         out_valid    <= 1'b0;
         out_addr     <= '0;
         corner_count <= '0;
         cx           <= '0;
         cy           <= '0;
         c            <= '0;
      end else begin
         done      <= 1'b0;
         eval      <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  corner_count <= '0;
                  cx           <= ADDR_W'(BORDER);
                  cy           <= ADDR_W'(BORDER);
                  c            <= FIRST_A;
                  rd_req       <= 1'b1;
                  rd_addr      <= FIRST_A;
                  adj_number   <= 4'd8;
                  busy         <= 1'b1;
                  state        <= S_CENTER;
               end
            end
            S_CENTER: begin
               if (rd_ack) begin
                  if (center_nz) begin
                     rd_addr    <= nb(c, 4'd0);
                     adj_number <= 4'd0;
                     state      <= S_ADJ;
                  end else begin
                     rd_req <= 1'b0;
                     state  <= S_NEXT;
                  end
               end
            end
            S_ADJ: begin
               if (rd_ack) begin
                  if (adj_number == 4'd7) begin
                     rd_req <= 1'b0;
                     eval   <= 1'b1;
                     state  <= S_EVAL;
                  end else begin
                     adj_number <= adj_number + 4'd1;
                     rd_addr    <= nb(c, adj_number + 4'd1);
                  end
               end
            end
            S_EVAL: state <= S_RESULT;
            S_RESULT: begin
               if (is_max) begin
                  out_valid <= 1'b1;
                  out_addr  <= c;
                  if (corner_count != 16'hFFFF) corner_count <= corner_count + 16'd1;
               end
               state <= S_NEXT;
            end
            S_NEXT: begin
               if (cx == ADDR_W'(X_LAST) && cy == ADDR_W'(Y_LAST)) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  // Stepping past the last column skips both borders to reach the next row.
                  if (cx == ADDR_W'(X_LAST)) begin
                     cx      <= ADDR_W'(BORDER);
                     cy      <= cy + ONE_A;
                     c       <= c + ROW_STEP;
                     rd_addr <= c + ROW_STEP;
                  end else begin
                     cx      <= cx + ONE_A;
                     c       <= c + ONE_A;
                     rd_addr <= c + ONE_A;
                  end
                  rd_req     <= 1'b1;
                  adj_number <= 4'd8;
                  state      <= S_CENTER;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nms_scheduler.sv
// Bench for nms_scheduler: a score-memory/datapath responder drives the handshake while
// a frame model predicts every read, maximum and cycle count.
module tb_nms_scheduler;
   localparam int W  = 30;
   localparam int H  = 30;
   localparam int AW = 15;
   localparam int B  = 3;

   // Handshake: a read transfers on a cycle where rd_req and rd_ack are both high at the
   // rising edge; rd_req/rd_addr/adj_number hold until then, rd_ack is ignored otherwise.
   logic          clock, reset, start;
   logic          busy, done, rd_req, rd_ack, center_nz, reg_wr, eval, is_max, out_valid;
   logic [AW-1:0] rd_addr, out_addr;
   logic [3:0]    adj_number;
   logic [15:0]   corner_count;
   logic [2:0]    fsm_state;

   nms_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BORDER(B)) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .center_nz(center_nz),
      .adj_number(adj_number), .reg_wr(reg_wr), .eval(eval), .is_max(is_max),
      .out_valid(out_valid), .out_addr(out_addr), .corner_count(corner_count),
      .fsm_state(fsm_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [AW+3:0] exp_q[$];
   logic [AW-1:0] exp_out_q[$];
   bit            nz_map [0:W*H-1];
   bit            max_map[0:W*H-1];
   int            exp_busy_base, exp_corners, extra_cycles;
   int            busy_cycles, done_count, ov_seen, delay_mode;
   bit            mon_en, pending, prev_eval, prev_last_ack, hold_prev;
   bit            ov_exp_cur, ov_exp_nxt;
   int            wait_cnt;
   logic [AW-1:0] cur_c, hold_addr;
   logic [3:0]    hold_adj;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int nb_off(input int k);
      case (k)
         0: return -W - 1;
         1: return -W;
         2: return -W + 1;
         3: return -1;
         4: return 1;
         5: return W - 1;
         6: return W;
         default: return W + 1;
      endcase
   endfunction

   // scoreboard model of one frame
   task automatic build_expect();
      exp_q.delete();
      exp_out_q.delete();
      exp_busy_base = 1;
      exp_corners   = 0;
      for (int y = B; y <= H - 1 - B; y++) begin
         for (int x = B; x <= W - 1 - B; x++) begin
            int c;
            c = y * W + x;
            exp_q.push_back({AW'(c), 4'd8});
            if (nz_map[c]) begin
               for (int k = 0; k < 8; k++) exp_q.push_back({AW'(c + nb_off(k)), 4'(k)});
               exp_busy_base += 12;
               if (max_map[c]) begin
                  exp_out_q.push_back(AW'(c));
                  exp_corners++;
               end
            end else begin
               exp_busy_base += 2;
            end
         end
      end
   endtask

   function automatic int pick_delay(input logic [AW-1:0] a, input logic [3:0] k);
      if (delay_mode == 0) return 0;
      if (a == AW'(94) && k == 4'd4) return 3;
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 2));
      return 0;
   endfunction

   // memory/datapath driver plus per-cycle monitor
   task automatic serve_cycle();
      bit hs;
      bit result_now;
      ov_exp_cur = ov_exp_nxt;
      result_now = prev_eval;
      ov_exp_nxt = result_now && max_map[cur_c];
      is_max     = result_now ? max_map[cur_c] : 1'($urandom_range(0, 1));
      if (rd_req) begin
         if (!pending) begin
            pending  = 1'b1;
            wait_cnt = pick_delay(rd_addr, adj_number);
            extra_cycles += wait_cnt;
         end
         if (wait_cnt == 0) begin
            rd_ack    = 1'b1;
            center_nz = (adj_number == 4'd8) ? nz_map[rd_addr] : 1'($urandom_range(0, 1));
            pending   = 1'b0;
         end else begin
            rd_ack    = 1'b0;
            center_nz = 1'($urandom_range(0, 1));
            wait_cnt--;
         end
      end else begin
         rd_ack    = 1'($urandom_range(0, 1));
         center_nz = 1'($urandom_range(0, 1));
         pending   = 1'b0;
      end
      #1;
      hs = rd_req && rd_ack;
      if (done) done_count++;
      if (mon_en) begin
         if (busy) busy_cycles++;
         check_val("reg_wr", reg_wr, hs);
         if (hold_prev) check_val("rd_hold", {rd_req, rd_addr, adj_number}, {1'b1, hold_addr, hold_adj});
         check_val("eval_timing", eval, prev_last_ack);
         check_val("out_valid", out_valid, ov_exp_cur);
         if (out_valid) begin
            check_val("out_queue_nonempty", exp_out_q.size() != 0, 1);
            if (exp_out_q.size() != 0) check_val("out_addr", out_addr, exp_out_q.pop_front());
            ov_seen++;
            check_val("corner_count_step", corner_count, ov_seen);
         end
         if (hs) begin
            check_val("rd_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               logic [AW+3:0] e;
               e = exp_q.pop_front();
               check_val("rd_addr_adj", {rd_addr, adj_number}, e);
               if (e[3:0] == 4'd8) cur_c = e[AW+3:4];
            end
         end
      end
      prev_eval     = eval;
      prev_last_ack = hs && adj_number == 4'd7;
      hold_prev     = rd_req && !rd_ack;
      hold_addr     = rd_addr;
      hold_adj      = adj_number;
   endtask

   initial begin
      forever begin
         @(negedge clock);
         serve_cycle();
      end
   end

   task automatic run_frame(input int mode, input bit poke_start);
      bit got_done;
      int done0;
      delay_mode   = mode;
      build_expect();
      extra_cycles = 0;
      busy_cycles  = 0;
      ov_seen      = 0;
      ov_exp_nxt   = 1'b0;
      done0        = done_count;
      got_done     = 1'b0;
      mon_en       = 1'b1;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      #2;
      check_val("first_rd", {rd_req, rd_addr, adj_number}, {1'b1, AW'(93), 4'd8});
      check_val("cc_cleared", corner_count, 0);
      for (int n = 0; n < 20000; n++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         @(negedge clock);
         start = poke_start && n == 40;
         #2;
      end
      start = 1'b0;
      check_val("done_seen", got_done, 1);
      check_val("busy_at_done", busy, 1);
      check_val("busy_cycles", busy_cycles, exp_busy_base + extra_cycles);
      check_val("corner_count", corner_count, exp_corners);
      check_val("rd_queue_left", exp_q.size(), 0);
      check_val("out_queue_left", exp_out_q.size(), 0);
      @(negedge clock);
      #2;
      check_val("busy_after_done", busy, 0);
      check_val("done_pulse_width", done, 0);
      check_val("done_count", done_count - done0, 1);
      mon_en = 1'b0;
   endtask

   task automatic random_maps();
      for (int i = 0; i < W * H; i++) begin
         nz_map[i]  = ($urandom_range(0, 7) == 0);
         max_map[i] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; rd_ack = 1'b0; center_nz = 1'b0; is_max = 1'b0;
      mon_en = 1'b0; pending = 1'b0; prev_eval = 1'b0; prev_last_ack = 1'b0; hold_prev = 1'b0;
      ov_exp_cur = 1'b0; ov_exp_nxt = 1'b0; cur_c = '0; delay_mode = 0; done_count = 0;
      repeat (3) @(negedge clock);
      #2;
      check_val("reset_state", {busy, done, rd_req, rd_addr, adj_number, reg_wr, eval,
                                out_valid, out_addr, corner_count, fsm_state}, 0);
      @(negedge clock);
      reset = 1'b0;

      // evaluated pixels, stalled neighbour 4 at 93, a non-max at 94, start poked mid-scan
      random_maps();
      nz_map[93] = 1'b1; max_map[93] = 1'b1;
      nz_map[94] = 1'b1; max_map[94] = 1'b0;
      nz_map[116] = 1'b1; nz_map[806] = 1'b1; max_map[806] = 1'b1;
      run_frame(1, 1'b1);

      // all-zero frame with immediate acks
      for (int i = 0; i < W * H; i++) begin
         nz_map[i]  = 1'b0;
         max_map[i] = 1'b0;
      end
      run_frame(0, 1'b0);

      // reset while loading neighbours
      nz_map[93] = 1'b1; max_map[93] = 1'b1;
      delay_mode = 0;
      d0 = done_count;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clock);
         #2;
         if (rd_req && adj_number != 4'd8) break;
      end
      check_val("reached_adj", {rd_req, adj_number != 4'd8}, 2'b11);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #2;
      check_val("reset_abort", {busy, done, rd_req, rd_addr, adj_number, reg_wr, eval,
                                out_valid, out_addr, corner_count, fsm_state}, 0);
      repeat (20) @(negedge clock);
      check_val("no_done_after_reset", done_count - d0, 0);
      check_val("idle_after_reset", busy, 0);
      exp_q.delete();
      exp_out_q.delete();
      prev_eval = 1'b0; prev_last_ack = 1'b0; hold_prev = 1'b0;

      // fresh frame after the abort
      random_maps();
      nz_map[93] = 1'b1; max_map[93] = 1'b1;
      run_frame(1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
